// File: rtl/legv8_alu_exec_if.sv
// Request/result bundle between register read and the EX-stage ALU.
// Latency: none, wiring only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface legv8_alu_exec_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [31:0]      instruction;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [3:0]       alu_ctrl;
    logic             illegal;
    logic             busy;

    modport master (
        output in_valid, alu_op, instruction, a, b, out_ready,
        input  in_ready, out_valid, result, zero, alu_ctrl, illegal, busy
    );

    modport slave (
        input  in_valid, alu_op, instruction, a, b, out_ready,
        output in_ready, out_valid, result, zero, alu_ctrl, illegal, busy
    );
endinterface

// File: rtl/legv8_alu_exec.sv
// LEGv8 ALU-control decode plus execute (ADD/SUB/AND/ORR/EOR/LSL/LSR/PASSB, iterative MUL).
// Latency: 1 cycle for single-cycle ops, WIDTH/MUL_BITS cycles for MUL.
// Backpressure: outputs held while out_valid && !out_ready; in_ready low during MUL or an undrained result.
module legv8_alu_exec #(
    parameter int WIDTH    = 64,
    parameter int MUL_BITS = 1
) (
    input logic             clk,
    input logic             rst_n,
    legv8_alu_exec_if.slave alu_bus
);
    localparam int MUL_CYC = WIDTH / MUL_BITS;
    localparam int CNT_W   = $clog2(MUL_CYC + 1);

    localparam logic [3:0] C_AND   = 4'b0000;
    localparam logic [3:0] C_ORR   = 4'b0001;
    localparam logic [3:0] C_ADD   = 4'b0010;
    localparam logic [3:0] C_EOR   = 4'b0011;
    localparam logic [3:0] C_SUB   = 4'b0110;
    localparam logic [3:0] C_PASSB = 4'b0111;
    localparam logic [3:0] C_LSL   = 4'b1000;
    localparam logic [3:0] C_LSR   = 4'b1001;
    localparam logic [3:0] C_MUL   = 4'b1010;
    localparam logic [3:0] C_ILL   = 4'b1111;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [3:0]       r_alu_ctrl;
    logic             r_illegal;
    logic [WIDTH-1:0] r_ma;
    logic [WIDTH-1:0] r_mb;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic [3:0]       w_ctrl;
    logic             w_illegal;
    logic             w_is_mul;
    logic [WIDTH-1:0] w_res;
    logic [5:0]       w_shamt;
    logic             w_shift_ok;
    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_pp;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_mul_done;
    logic             w_unused_instr;

    assign w_shamt        = alu_bus.instruction[15:10];
    assign w_shift_ok     = (32'(w_shamt) < WIDTH);
    assign w_unused_instr = ^{alu_bus.instruction[20:16], alu_bus.instruction[9:0]};

    assign w_in_ready = (r_state == ST_IDLE) && (!r_out_valid || alu_bus.out_ready);
    assign w_accept   = alu_bus.in_valid && w_in_ready;
    assign w_mul_done = (r_cnt == CNT_W'(MUL_CYC - 1));
    assign w_acc_next = r_acc + w_pp;

    assign alu_bus.in_ready  = w_in_ready;
    assign alu_bus.out_valid = r_out_valid;
    assign alu_bus.result    = r_result;
    assign alu_bus.zero      = r_zero;
    assign alu_bus.alu_ctrl  = r_alu_ctrl;
    assign alu_bus.illegal   = r_illegal;
    assign alu_bus.busy      = (r_state == ST_MUL);

    // Decode {ALUOp, opcode} and compute the single-cycle result; ALUOp wins over the opcode.
    always_comb begin
        w_ctrl    = C_ILL;
        w_illegal = 1'b0;
        w_is_mul  = 1'b0;
        w_res     = '0;
        if (alu_bus.alu_op == 2'b00) begin
            w_ctrl = C_ADD;
            w_res  = alu_bus.a + alu_bus.b;
        end else if (alu_bus.alu_op[0]) begin
            w_ctrl = C_PASSB;
            w_res  = alu_bus.b;
        end else begin
            case (alu_bus.instruction[31:21])
                11'b10001011000: begin w_ctrl = C_ADD; w_res = alu_bus.a + alu_bus.b; end
                11'b11001011000: begin w_ctrl = C_SUB; w_res = alu_bus.a - alu_bus.b; end
                11'b10001010000: begin w_ctrl = C_AND; w_res = alu_bus.a & alu_bus.b; end
                11'b10101010000: begin w_ctrl = C_ORR; w_res = alu_bus.a | alu_bus.b; end
                11'b11001010000: begin w_ctrl = C_EOR; w_res = alu_bus.a ^ alu_bus.b; end
                11'b11010011011: begin
                    w_ctrl = C_LSL;
                    w_res  = w_shift_ok ? (alu_bus.a << w_shamt) : '0;
                end
                11'b11010011010: begin
                    w_ctrl = C_LSR;
                    w_res  = w_shift_ok ? (alu_bus.a >> w_shamt) : '0;
                end
                11'b10011011000: begin w_ctrl = C_MUL; w_is_mul = 1'b1; end
                default: begin w_ctrl = C_ILL; w_illegal = 1'b1; w_res = '0; end
            endcase
        end
    end

    // Partial product of the shifted multiplicand and the next MUL_BITS multiplier bits.
    always_comb begin
        w_pp = '0;
        for (int j = 0; j < MUL_BITS; j++) begin
            if (r_mb[j]) begin
                w_pp = w_pp + (r_ma << j);
            end
        end
    end

    // Control FSM with registered result outputs and the shift-add multiplier datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_alu_ctrl  <= 4'b0000;
            r_illegal   <= 1'b0;
            r_ma        <= '0;
            r_mb        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_is_mul) begin
                        r_ma        <= alu_bus.a;
                        r_mb        <= alu_bus.b;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b0;
                        r_state     <= ST_MUL;
                    end else if (w_accept) begin
                        r_result    <= w_res;
                        r_zero      <= (w_res == '0);
                        r_alu_ctrl  <= w_ctrl;
                        r_illegal   <= w_illegal;
                        r_out_valid <= 1'b1;
                    end else if (alu_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                ST_MUL: begin
                    r_acc <= w_acc_next;
                    r_ma  <= r_ma << MUL_BITS;
                    r_mb  <= r_mb >> MUL_BITS;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_mul_done) begin
                        r_result    <= w_acc_next;
                        r_zero      <= (w_acc_next == '0);
                        r_alu_ctrl  <= C_MUL;
                        r_illegal   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else if (alu_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_legv8_alu_exec.sv
// Bench for legv8_alu_exec: directed cases plus random traffic against a transaction-level model.
// Two instances (MUL_BITS=1 and MUL_BITS=4) share the stimulus; sel picks the one under test.
// The idle instance sees in_valid=0 and out_ready=1.
module tb_legv8_alu_exec;
    localparam int W = 64;

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;
    localparam logic [10:0] OP_EOR = 11'b11001010000;
    localparam logic [10:0] OP_LSL = 11'b11010011011;
    localparam logic [10:0] OP_LSR = 11'b11010011010;
    localparam logic [10:0] OP_MUL = 11'b10011011000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          sel = 1'b0;
    logic          t_vld = 1'b0;
    logic [1:0]    t_op = 2'b00;
    logic [31:0]   t_ins = '0;
    logic [W-1:0]  t_a = '0;
    logic [W-1:0]  t_b = '0;
    logic          t_ordy = 1'b1;

    legv8_alu_exec_if #(.WIDTH(W)) if1 ();
    legv8_alu_exec_if #(.WIDTH(W)) if4 ();

    legv8_alu_exec #(.WIDTH(W), .MUL_BITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .alu_bus(if1.slave));
    legv8_alu_exec #(.WIDTH(W), .MUL_BITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .alu_bus(if4.slave));

    assign if1.in_valid    = t_vld & ~sel;
    assign if4.in_valid    = t_vld & sel;
    assign if1.alu_op      = t_op;
    assign if4.alu_op      = t_op;
    assign if1.instruction = t_ins;
    assign if4.instruction = t_ins;
    assign if1.a           = t_a;
    assign if4.a           = t_a;
    assign if1.b           = t_b;
    assign if4.b           = t_b;
    assign if1.out_ready   = sel ? 1'b1 : t_ordy;
    assign if4.out_ready   = sel ? t_ordy : 1'b1;

    logic         d_rdy, d_ov, d_zero, d_ill, d_busy;
    logic [W-1:0] d_res;
    logic [3:0]   d_ctrl;
    assign d_rdy  = sel ? if4.in_ready  : if1.in_ready;
    assign d_ov   = sel ? if4.out_valid : if1.out_valid;
    assign d_res  = sel ? if4.result    : if1.result;
    assign d_zero = sel ? if4.zero      : if1.zero;
    assign d_ctrl = sel ? if4.alu_ctrl  : if1.alu_ctrl;
    assign d_ill  = sel ? if4.illegal   : if1.illegal;
    assign d_busy = sel ? if4.busy      : if1.busy;

    int n_vec = 0;
    int n_bad = 0;

    // Model of what the consumer should see.
    logic         m_ov, m_zero, m_ill;
    logic [W-1:0] m_res;
    logic [3:0]   m_ctrl;
    int           m_left;
    int           n_mul;
    logic [W-1:0] p_res;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [10:0] opc, input logic [5:0] sh);
        logic [4:0] f1;
        logic [9:0] f2;
        f1 = 5'($urandom);
        f2 = 10'($urandom);
        return {opc, f1, sh, f2};
    endfunction

    // Reference semantics straight from the instruction definitions.
    function automatic void ref_op(input logic [1:0] op, input logic [31:0] ins,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [3:0] ctrl, output logic ill,
                                   output logic [W-1:0] res, output logic is_mul);
        int sh;
        sh     = int'(ins[15:10]);
        ill    = 1'b0;
        is_mul = 1'b0;
        if (op == 2'b00) begin
            ctrl = 4'b0010; res = a + b;
        end else if (op[0]) begin
            ctrl = 4'b0111; res = b;
        end else begin
            case (ins[31:21])
                OP_ADD: begin ctrl = 4'b0010; res = a + b; end
                OP_SUB: begin ctrl = 4'b0110; res = a - b; end
                OP_AND: begin ctrl = 4'b0000; res = a & b; end
                OP_ORR: begin ctrl = 4'b0001; res = a | b; end
                OP_EOR: begin ctrl = 4'b0011; res = a ^ b; end
                OP_LSL: begin ctrl = 4'b1000; res = (sh >= W) ? '0 : a << sh; end
                OP_LSR: begin ctrl = 4'b1001; res = (sh >= W) ? '0 : a >> sh; end
                OP_MUL: begin ctrl = 4'b1010; res = a * b; is_mul = 1'b1; end
                default: begin ctrl = 4'b1111; res = '0; ill = 1'b1; end
            endcase
        end
    endfunction

    task automatic model_reset();
        m_ov = 1'b0; m_res = '0; m_zero = 1'b1; m_ctrl = 4'b0000; m_ill = 1'b0;
        m_left = 0; p_res = '0;
    endtask

    task automatic do_reset();
        t_vld  = 1'b0;
        t_ordy = 1'b1;
        rst_n  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: check outputs, apply inputs, check in_ready, advance the model, cross the edge.
    task automatic cyc(input logic vld, input logic [1:0] op, input logic [31:0] ins,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy,
                       output logic acc);
        logic       exp_rdy, ill, is_mul;
        logic [3:0] ctrl;
        logic [W-1:0] res;
        chk("out_valid", 64'(d_ov), 64'(m_ov));
        chk("busy", 64'(d_busy), 64'(m_left > 0));
        chk("result", d_res, m_res);
        chk("zero", 64'(d_zero), 64'(m_zero));
        chk("alu_ctrl", 64'(d_ctrl), 64'(m_ctrl));
        chk("illegal", 64'(d_ill), 64'(m_ill));
        t_vld = vld; t_op = op; t_ins = ins; t_a = a; t_b = b; t_ordy = ordy;
        #1;
        exp_rdy = (m_left == 0) && (!m_ov || ordy);
        chk("in_ready", 64'(d_rdy), 64'(exp_rdy));
        acc = vld && exp_rdy;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_res = p_res; m_zero = (p_res == '0); m_ctrl = 4'b1010; m_ill = 1'b0; m_ov = 1'b1;
            end else if (ordy) begin
                m_ov = 1'b0;
            end
        end else if (acc) begin
            ref_op(op, ins, a, b, ctrl, ill, res, is_mul);
            if (is_mul) begin
                m_left = n_mul; p_res = res; m_ov = 1'b0;
            end else begin
                m_res = res; m_zero = (res == '0); m_ctrl = ctrl; m_ill = ill; m_ov = 1'b1;
            end
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, '0, '0, '0, 1'b1, acc);
    endtask

    task automatic rand_run(input int n);
        logic [10:0] opc_tab [8];
        logic         hv, vld, ordy, acc;
        logic [1:0]   op;
        logic [31:0]  ins;
        logic [W-1:0] a, b;
        int           k;
        opc_tab = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_LSL, OP_LSR, OP_MUL};
        hv = 1'b0; vld = 1'b0; op = 2'b10; ins = '0; a = '0; b = '0;
        for (int i = 0; i < n; i++) begin
            if (!hv) begin
                vld = ($urandom_range(0, 3) != 0);
                op  = ($urandom_range(0, 9) < 7) ? 2'b10 : 2'($urandom);
                k   = $urandom_range(0, 8);
                if (k == 7 && $urandom_range(0, 3) != 0) k = 0;
                ins = (k == 8) ? mk(11'($urandom), 6'($urandom)) : mk(opc_tab[k], 6'($urandom));
                a   = {$urandom, $urandom};
                b   = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 15));
            end
            ordy = ($urandom_range(0, 3) != 0);
            cyc(vld, op, ins, a, b, ordy, acc);
            hv = vld && !acc;
        end
    endtask

    initial begin
        logic acc;
        logic [W-1:0] held;
        n_mul = 64;
        do_reset();

        // Reset values and in_ready=1 right after reset release.
        idle(1);

        cyc(1'b1, 2'b10, mk(OP_ADD, 6'd0), 64'd5, 64'd7, 1'b1, acc);
        chk("add_res", d_res, 64'd12);
        chk("add_ctrl", 64'(d_ctrl), 64'h2);
        cyc(1'b1, 2'b10, mk(OP_SUB, 6'd0), 64'd3, 64'd3, 1'b1, acc);
        chk("sub_zero", 64'(d_zero), 64'd1);
        cyc(1'b1, 2'b10, mk(OP_SUB, 6'd0), 64'd0, 64'd1, 1'b1, acc);
        chk("sub_wrap", d_res, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc(1'b1, 2'b01, mk(OP_ADD, 6'd0), 64'd9, 64'h55, 1'b1, acc);
        chk("passb", d_res, 64'h55);
        cyc(1'b1, 2'b10, mk(11'h7FF, 6'd0), 64'd9, 64'd9, 1'b1, acc);
        chk("illegal", 64'(d_ill), 64'd1);
        cyc(1'b1, 2'b10, mk(OP_LSL, 6'd63), 64'd1, 64'd0, 1'b1, acc);
        chk("lsl63", d_res, 64'h8000_0000_0000_0000);
        cyc(1'b1, 2'b10, mk(OP_LSR, 6'd63), 64'h8000_0000_0000_0000, 64'd0, 1'b1, acc);
        chk("lsr63", d_res, 64'd1);

        // MUL with 1 bit per cycle: 64 busy cycles.
        cyc(1'b1, 2'b10, mk(OP_MUL, 6'd0), 64'hFFFF_FFFF, 64'h1_0000_0001, 1'b1, acc);
        idle(64);
        chk("mul1_vld", 64'(d_ov), 64'd1);
        chk("mul1_res", d_res, 64'hFFFF_FFFF_FFFF_FFFF);

        // Backpressure: AND result held while ORR waits; ORR accepted on the draining cycle.
        cyc(1'b1, 2'b10, mk(OP_AND, 6'd0), 64'hF0F0, 64'hFF00, 1'b1, acc);
        held = d_res;
        chk("and_res", held, 64'hF000);
        for (int i = 0; i < 5; i++) cyc(1'b1, 2'b10, mk(OP_ORR, 6'd0), 64'hF0F0, 64'hFF00, 1'b0, acc);
        chk("and_held", d_res, held);
        cyc(1'b1, 2'b10, mk(OP_ORR, 6'd0), 64'hF0F0, 64'hFF00, 1'b1, acc);
        chk("orr_acc", 64'(acc), 64'd1);
        chk("orr_res", d_res, 64'hFFF0);

        // Asynchronous reset in the middle of a MUL.
        cyc(1'b1, 2'b10, mk(OP_MUL, 6'd0), 64'd3, 64'd5, 1'b1, acc);
        idle(10);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ov", 64'(d_ov), 64'd0);
        chk("rst_busy", 64'(d_busy), 64'd0);
        chk("rst_zero", 64'(d_zero), 64'd1);
        do_reset();
        idle(1);

        rand_run(1500);

        // Same MUL on the 4-bits-per-cycle instance: 16 busy cycles.
        rst_n = 1'b0;
        sel = 1'b1;
        n_mul = 16;
        do_reset();
        idle(1);
        cyc(1'b1, 2'b10, mk(OP_MUL, 6'd0), 64'hFFFF_FFFF, 64'h1_0000_0001, 1'b1, acc);
        idle(16);
        chk("mul4_vld", 64'(d_ov), 64'd1);
        chk("mul4_res", d_res, 64'hFFFF_FFFF_FFFF_FFFF);
        rand_run(600);
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
